// File: rtl/adc_pkg.sv
// Shared sample types for the ADC capture path: raw sample width, the raw
// sample type, and the frame-tagged entry stored in the sample FIFO.
package adc_pkg;

  localparam int SAMPLE_W = 12;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    logic    eof;
    logic    sof;
    sample_t sample;
  } framed_sample_t;

  localparam int FRAMED_W = $bits(framed_sample_t);

endpackage

// File: rtl/sample_fifo_ram.sv
// Simple dual-port storage for the sample framer: one synchronous write
// port and one asynchronous read port, DEPTH entries of framed samples.
// Contents are intentionally not reset.
module sample_fifo_ram
  import adc_pkg::*;
#(
  parameter int  DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  framed_sample_t wr_data,
  input  logic [AW-1:0]  rd_addr,
  output framed_sample_t rd_data
);

  framed_sample_t mem [DEPTH];

  // Write port: store one tagged sample per accepted push.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_framer.sv
// Sample framer: buffers ADC samples in a first-word-fall-through FIFO and
// tags each accepted sample with start/end-of-frame flags at push time.
// Optional feature: define SAMPLE_FRAMER_OVF_COUNT_EN to add the saturating
// dropped-sample counter output ovf_count.
module sample_framer
  import adc_pkg::*;
#(
  parameter int  DEPTH     = 64,
  parameter int  FRAME_LEN = 256,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                new_sample_in,
  input  logic                clear,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic                out_eof,
  output logic [LW-1:0]       level,
`ifdef SAMPLE_FRAMER_OVF_COUNT_EN
  output logic [15:0]         ovf_count,
`endif
  output logic                overflow
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  logic [LW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic [15:0]    frame_idx;
  logic           full, push, pop, drop;
  framed_sample_t wr_entry, rd_entry, head_nxt;

  // Full when the pointers address the same slot but differ in wrap bit.
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Handshake decode, tagging and next-state pointers; the next head comes
  // from the word being written when the FIFO would otherwise be empty.
  always_comb begin
    pop             = out_valid & out_ready;
    push            = new_sample_in & (~full | pop) & ~clear;
    drop            = new_sample_in & full & ~pop & ~clear;
    wr_entry        = '0;
    wr_entry.sample = sample_in;
    wr_entry.sof    = (frame_idx == 16'd0);
    wr_entry.eof    = (frame_idx == LAST_IDX);
    wr_ptr_nxt      = wr_ptr + LW'(push);
    rd_ptr_nxt      = rd_ptr + LW'(pop);
    level_nxt       = level + LW'(push) - LW'(pop);
    head_nxt        = (push && (rd_ptr_nxt == wr_ptr)) ? wr_entry : rd_entry;
  end

  sample_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_nxt[AW-1:0]),
    .rd_data (rd_entry)
  );

  // Pointer and occupancy state; clear empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
    end
  end

  // Frame position counter: advances on accepted samples only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_idx <= '0;
    end else if (clear) begin
      frame_idx <= '0;
    end else if (push) begin
      frame_idx <= (frame_idx == LAST_IDX) ? 16'd0 : frame_idx + 16'd1;
    end
  end

  // Registered head-of-FIFO view; data and tags hold while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= (level_nxt != '0);
      if (level_nxt != '0) begin
        out_data <= head_nxt.sample;
        out_sof  <= head_nxt.sof;
        out_eof  <= head_nxt.eof;
      end
    end
  end

  // Sticky dropped-sample flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef SAMPLE_FRAMER_OVF_COUNT_EN
  // Saturating count of dropped samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (clear) begin
      ovf_count <= '0;
    end else if (drop && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_framer.sv
// Self-checking bench for sample_framer (DEPTH = 4, FRAME_LEN = 4) with a
// queue-based scoreboard of accepted, tagged samples.
// Define SAMPLE_FRAMER_OVF_COUNT_EN to also check ovf_count.
module tb_sample_framer;
  import adc_pkg::*;

  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 4;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [11:0]   sample_in = '0;
  logic          new_sample_in = 1'b0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic [11:0]   out_data;
  logic          out_valid;
  logic          out_sof;
  logic          out_eof;
  logic [LW-1:0] level;
  logic          overflow;
`ifdef SAMPLE_FRAMER_OVF_COUNT_EN
  logic [15:0]   ovf_count;
`endif

  int compared = 0;
  int mismatched = 0;

  framed_sample_t m_q[$];
  framed_sample_t m_out;
  int             m_idx;
  bit             m_ovf;
  int             m_ovfc;

  sample_framer #(
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_in     (sample_in),
    .new_sample_in (new_sample_in),
    .clear         (clear),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .level         (level),
`ifdef SAMPLE_FRAMER_OVF_COUNT_EN
    .ovf_count     (ovf_count),
`endif
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_q.delete();
    m_idx  = 0;
    m_ovf  = 0;
    m_ovfc = 0;
  endtask

  // Advance the model by one edge using the currently driven inputs, then
  // move the bench to 1 time unit after that edge.
  task automatic tick();
    bit pop, full, push, drop;
    framed_sample_t e;
    pop  = (m_q.size() > 0) && out_ready;
    full = (m_q.size() == DEPTH);
    if (clear) begin
      model_clear();
    end else begin
      push = new_sample_in && (!full || pop);
      drop = new_sample_in && full && !pop;
      if (pop) e = m_q.pop_front();
      if (push) begin
        e.sample = sample_in;
        e.sof    = (m_idx == 0);
        e.eof    = (m_idx == FRAME_LEN - 1);
        m_q.push_back(e);
        m_idx = (m_idx == FRAME_LEN - 1) ? 0 : m_idx + 1;
      end
      if (drop) begin
        m_ovf = 1;
        if (m_ovfc < 65535) m_ovfc++;
      end
      if (m_q.size() > 0) m_out = m_q[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    compared++; if (level !== '0) begin mismatched++; $display("FAIL rst_level got=%0d exp=0", level); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    compared++; if (out_data !== 12'h000) begin mismatched++; $display("FAIL rst_data got=%h exp=000", out_data); end
    compared++; if ({out_sof, out_eof} !== 2'b00) begin mismatched++; $display("FAIL rst_tags got=%b exp=00", {out_sof, out_eof}); end
`ifdef SAMPLE_FRAMER_OVF_COUNT_EN
    compared++; if (ovf_count !== 16'd0) begin mismatched++; $display("FAIL rst_ovf_count got=%0d exp=0", ovf_count); end
`endif
    model_clear();
    m_out = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    compared++; if (out_valid !== 1'b0 || level !== '0) begin mismatched++; $display("FAIL rst_idle got=%b/%0d exp=0/0", out_valid, level); end
  endtask

  task automatic test_frame_tags();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      sample_in = 12'(k);
      new_sample_in = 1'b1;
      tick();
      new_sample_in = 1'b0;
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL tag_valid k=%0d got=%b exp=1", k, out_valid); end
      compared++; if (out_data !== 12'(k)) begin mismatched++; $display("FAIL tag_data got=%h exp=%h", out_data, 12'(k)); end
      compared++; if (out_sof !== (k % 4 == 1)) begin mismatched++; $display("FAIL tag_sof k=%0d got=%b exp=%b", k, out_sof, (k % 4 == 1)); end
      compared++; if (out_eof !== (k % 4 == 0)) begin mismatched++; $display("FAIL tag_eof k=%0d got=%b exp=%b", k, out_eof, (k % 4 == 0)); end
      tick();
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL tag_drained k=%0d got=%b exp=0", k, out_valid); end
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      sample_in = 12'(16 + k);
      new_sample_in = 1'b1;
      tick();
    end
    new_sample_in = 1'b0;
    tick();
    compared++; if (level !== LW'(4)) begin mismatched++; $display("FAIL ovf_level got=%0d exp=4", level); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
`ifdef SAMPLE_FRAMER_OVF_COUNT_EN
    compared++; if (ovf_count !== 16'd2) begin mismatched++; $display("FAIL ovf_count got=%0d exp=2", ovf_count); end
`endif
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      compared++; if (out_valid !== 1'b1 || out_data !== 12'(16 + k)) begin mismatched++; $display("FAIL ovf_drain k=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, 12'(16 + k)); end
      compared++; if ({out_sof, out_eof} !== {k == 1, k == 4}) begin mismatched++; $display("FAIL ovf_tags k=%0d got=%b exp=%b", k, {out_sof, out_eof}, {k == 1, k == 4}); end
      tick();
    end
    tick();
    compared++; if (out_valid !== 1'b0 || level !== '0) begin mismatched++; $display("FAIL ovf_empty got=%b/%0d exp=0/0", out_valid, level); end
    compared++; if (out_data !== 12'h014) begin mismatched++; $display("FAIL empty_hold got=%h exp=014", out_data); end
  endtask

  task automatic test_full_pop();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    compared++; if (overflow !== 1'b0 || level !== '0) begin mismatched++; $display("FAIL fp_clear got=%b/%0d exp=0/0", overflow, level); end
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sample_in = 12'(32 + k);
      new_sample_in = 1'b1;
      tick();
    end
    compared++; if (level !== LW'(4)) begin mismatched++; $display("FAIL fp_fill got=%0d exp=4", level); end
    sample_in = 12'h025;
    out_ready = 1'b1;
    tick();
    new_sample_in = 1'b0;
    out_ready = 1'b0;
    compared++; if (level !== LW'(4)) begin mismatched++; $display("FAIL fp_level got=%0d exp=4", level); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL fp_overflow got=%b exp=0", overflow); end
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      compared++; if (out_valid !== 1'b1 || out_data !== 12'(32 + k)) begin mismatched++; $display("FAIL fp_drain k=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, 12'(32 + k)); end
      compared++; if (out_sof !== (k == 5)) begin mismatched++; $display("FAIL fp_sof k=%0d got=%b exp=%b", k, out_sof, (k == 5)); end
      tick();
    end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL fp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sample_in = 12'(48 + k);
      new_sample_in = 1'b1;
      tick();
    end
    new_sample_in = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    compared++; if (level !== LW'(3) || overflow !== 1'b1) begin mismatched++; $display("FAIL clr_pre got=%0d/%b exp=3/1", level, overflow); end
    clear = 1'b1;
    sample_in = 12'h034;
    new_sample_in = 1'b1;
    tick();
    clear = 1'b0;
    new_sample_in = 1'b0;
    compared++; if (level !== '0) begin mismatched++; $display("FAIL clr_level got=%0d exp=0", level); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL clr_valid got=%b exp=0", out_valid); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL clr_overflow got=%b exp=0", overflow); end
`ifdef SAMPLE_FRAMER_OVF_COUNT_EN
    compared++; if (ovf_count !== 16'd0) begin mismatched++; $display("FAIL clr_ovf_count got=%0d exp=0", ovf_count); end
`endif
    sample_in = 12'h035;
    new_sample_in = 1'b1;
    tick();
    new_sample_in = 1'b0;
    compared++; if (out_valid !== 1'b1 || out_data !== 12'h035 || out_sof !== 1'b1) begin mismatched++; $display("FAIL clr_sof got=%b/%h/%b exp=1/035/1", out_valid, out_data, out_sof); end
  endtask

  task automatic test_async_reset();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    out_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      sample_in = 12'(64 + k);
      new_sample_in = 1'b1;
      tick();
    end
    new_sample_in = 1'b0;
    compared++; if (level !== LW'(2) || out_data !== 12'h041) begin mismatched++; $display("FAIL ar_pre got=%0d/%h exp=2/041", level, out_data); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (out_valid !== 1'b0 || level !== '0) begin mismatched++; $display("FAIL ar_state got=%b/%0d exp=0/0", out_valid, level); end
    compared++; if (out_data !== 12'h000 || {out_sof, out_eof} !== 2'b00) begin mismatched++; $display("FAIL ar_out got=%h/%b exp=000/00", out_data, {out_sof, out_eof}); end
    model_clear();
    m_out = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    sample_in = 12'h043;
    new_sample_in = 1'b1;
    out_ready = 1'b1;
    tick();
    new_sample_in = 1'b0;
    compared++; if (out_valid !== 1'b1 || out_data !== 12'h043 || out_sof !== 1'b1 || out_eof !== 1'b0) begin mismatched++; $display("FAIL ar_sof got=%b/%h/%b/%b exp=1/043/1/0", out_valid, out_data, out_sof, out_eof); end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int cyc = 0;
    int run = 0;
    int rdy_pct;
    bit pop_obs;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    while (pulses < 10000 && cyc < 60000) begin
      rdy_pct = ((cyc / 500) % 2 == 1) ? 30 : 85;
      new_sample_in = 1'($urandom_range(0, 1));
      sample_in = 12'($urandom);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (new_sample_in) pulses++;
      pop_obs = out_valid && out_ready;
      if (pop_obs) begin
        if (out_sof) run = 0;
        if (out_eof) begin
          compared++; if (run !== FRAME_LEN - 1) begin mismatched++; $display("FAIL bb_span got=%0d exp=%0d", run + 1, FRAME_LEN); end
        end
        run++;
      end
      tick();
      cyc++;
      compared++; if (out_valid !== (m_q.size() > 0)) begin mismatched++; $display("FAIL bb_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (m_q.size() > 0)); end
      compared++; if (level !== LW'(m_q.size())) begin mismatched++; $display("FAIL bb_level cyc=%0d got=%0d exp=%0d", cyc, level, m_q.size()); end
      compared++; if (overflow !== m_ovf) begin mismatched++; $display("FAIL bb_overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf); end
      compared++; if ({out_eof, out_sof, out_data} !== m_out) begin mismatched++; $display("FAIL bb_head cyc=%0d got=%b/%b/%h exp=%b/%b/%h", cyc, out_eof, out_sof, out_data, m_out.eof, m_out.sof, m_out.sample); end
`ifdef SAMPLE_FRAMER_OVF_COUNT_EN
      compared++; if (ovf_count !== 16'(m_ovfc)) begin mismatched++; $display("FAIL bb_ovf_count cyc=%0d got=%0d exp=%0d", cyc, ovf_count, m_ovfc); end
`endif
    end
    new_sample_in = 1'b0;
    out_ready = 1'b0;
    compared++; if (pulses < 10000) begin mismatched++; $display("FAIL bb_budget got=%0d exp=10000 pulses", pulses); end
  endtask

  initial begin
    test_reset();
    test_frame_tags();
    test_overflow();
    test_full_pop();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
